// File: rtl/timer_scheduler.sv
// -----------------------------------------------------------------------------
// timer_scheduler
//
// Purpose:
//   Shares one programmable countdown timer among NUM_REQ requesters. Requests
//   are granted round-robin. The granted delay is loaded into the timer and the
//   scheduler waits for the timer's expiry pulse. It then returns a one-cycle
//   done pulse to the owner.
//
// Optional feature (compile-time macro):
//   TIMER_SCHED_CANCEL_EN - adds the req_cancel input. A cancel from the
//                           current owner in PROGRAM or WAIT abandons the grant
//                           and issues no done pulse.
//
// Parameters:
//   NUM_REQ       number of requesters (2..8)
//   ID_W          width of the grant index
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   req_valid     per-requester request
//   req_delay     per-requester 32-bit delay, slice [32*i +: 32]
//   req_cancel    per-requester cancel (TIMER_SCHED_CANCEL_EN only)
//   req_ready     one-hot accept strobe (combinational, IDLE only)
//   done          registered one-hot expiry pulse for the owner
//   busy          high whenever the FSM is not in IDLE
//   grant_id      index of the current / most recent owner
//   set_timer     registered one-cycle timer program strobe
//   timer_set_val value loaded into the timer, held after programming
//   timer_is_high expiry pulse from the timer
// -----------------------------------------------------------------------------
module timer_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*32-1:0] req_delay,
`ifdef TIMER_SCHED_CANCEL_EN
   input  logic [NUM_REQ-1:0]    req_cancel,
`endif
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    done,
   output logic                  busy,
   output logic [ID_W-1:0]       grant_id,
   output logic                  set_timer,
   output logic [31:0]           timer_set_val,
   input  logic                  timer_is_high
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROGRAM,
      S_WAIT,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [ID_W-1:0]    r_last_grant;
   logic [ID_W-1:0]    r_grant_id;
   logic [31:0]        r_delay_q;
   logic [NUM_REQ-1:0] r_done;
   logic               r_set_timer;

   logic               w_any_valid;
   logic [ID_W-1:0]    w_winner;
   logic               w_cancel;

   // Round-robin pick. The loop walks the offsets from farthest to nearest.
   // The requester closest after last_grant is therefore the final one
   // written, and it wins.
   always_comb begin : rr_arbiter
      int idx;
      // NOTE: every variable written here gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      idx         = 0;
      w_any_valid = 1'b0;
      w_winner    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(r_last_grant) + k) % NUM_REQ;
         if (req_valid[idx]) begin
            w_any_valid = 1'b1;
            w_winner    = ID_W'(idx);
         end
      end
   end

   // Ready is combinational so a requester sees its grant in the same cycle.
   // It is forced low while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (!rst && (r_state == S_IDLE) && w_any_valid) begin
         req_ready[w_winner] = 1'b1;
      end
   end

`ifdef TIMER_SCHED_CANCEL_EN
   // Only the owner's cancel bit matters. The FSM decides when it takes effect.
   assign w_cancel = req_cancel[r_grant_id];
`else
   assign w_cancel = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only. Every register
   // then samples pre-edge values, whatever order the statements are written in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_grant_id   <= '0;
         r_delay_q    <= '0;
         r_done       <= '0;
         r_set_timer  <= 1'b0;
      end else begin
         // Both strobes are single-cycle pulses by default.
         r_set_timer <= 1'b0;
         r_done      <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any_valid) begin
                  r_delay_q    <= req_delay[32*int'(w_winner) +: 32];
                  r_grant_id   <= w_winner;
                  r_last_grant <= w_winner;
                  r_set_timer  <= 1'b1;
                  r_state      <= S_PROGRAM;
               end
            end
            // timer_is_high is deliberately ignored here. An expiry left over
            // from an earlier programming must not complete this grant.
            S_PROGRAM: begin
               r_state <= w_cancel ? S_IDLE : S_WAIT;
            end
            // A cancel wins over a simultaneous expiry, so a cancelled grant
            // never produces done.
            S_WAIT: begin
               if (w_cancel) begin
                  r_state <= S_IDLE;
               end else if (timer_is_high) begin
                  r_done[r_grant_id] <= 1'b1;
                  r_state            <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign done          = r_done;
   assign busy          = (r_state != S_IDLE);
   assign grant_id      = r_grant_id;
   assign set_timer     = r_set_timer;
   assign timer_set_val = r_delay_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_timer_scheduler
//
// Purpose:
//   Directed plus randomized bench for timer_scheduler (NUM_REQ = 4). The
//   reference model works at the transaction level: it keeps the last granted
//   index and predicts each winner by scanning requesters in circular order.
//   The timer is modelled by pulsing timer_is_high after a chosen number of
//   WAIT cycles.
//   Define TIMER_SCHED_CANCEL_EN to also exercise the cancel feature.
// -----------------------------------------------------------------------------
module tb_timer_scheduler;

   localparam int N = 4;

   logic          clk;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N*32-1:0] req_delay;
`ifdef TIMER_SCHED_CANCEL_EN
   logic [N-1:0]  req_cancel;
`endif
   logic [N-1:0]  req_ready;
   logic [N-1:0]  done;
   logic          busy;
   logic [1:0]    grant_id;
   logic          set_timer;
   logic [31:0]   timer_set_val;
   logic          timer_is_high;

   int checks = 0;
   int errors = 0;

   // Reference model: the last accepted requester, and the owner the DUT
   // should report on grant_id.
   int model_last = N - 1;
   int model_gid  = 0;

   timer_scheduler #(.NUM_REQ(N)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_delay     (req_delay),
`ifdef TIMER_SCHED_CANCEL_EN
      .req_cancel    (req_cancel),
`endif
      .req_ready     (req_ready),
      .done          (done),
      .busy          (busy),
      .grant_id      (grant_id),
      .set_timer     (set_timer),
      .timer_set_val (timer_set_val),
      .timer_is_high (timer_is_high)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Winner is the first requester after 'last', scanning in circular order.
   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // One complete grant. Entered at a negedge with the DUT in IDLE, and
   // returns at the negedge where the DUT is back in IDLE.
   // req_valid stays applied for the whole grant.
   task automatic do_grant(input logic [N-1:0] valid, input int lat,
                           input bit prog_stale, input bit idle_stale,
                           input bit use_fixed, input logic [31:0] fixed,
                           output int w);
      logic [31:0] dl [N];
      logic [N-1:0] exp_oh;
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, '0);
      check("idle_gid_hold", grant_id, model_gid);
      if (idle_stale) begin
         // An expiry pulse in IDLE with no request must do nothing.
         req_valid     = '0;
         timer_is_high = 1'b1;
         #1;
         check("idle_stale_ready", req_ready, '0);
         @(negedge clk);
         timer_is_high = 1'b0;
         check("idle_stale_busy", busy, 1'b0);
         check("idle_stale_done", done, '0);
      end
      for (int i = 0; i < N; i++) begin
         dl[i] = use_fixed ? fixed : $urandom;
         req_delay[32*i +: 32] = dl[i];
      end
      req_valid = valid;
      #1;
      w      = rr_pick(valid, model_last);
      exp_oh = N'(1) << w;
      check("ready_onehot", req_ready, exp_oh);
      @(negedge clk);                       // accept edge passed: PROGRAM
      model_last = w;
      model_gid  = w;
      check("prog_set_timer", set_timer, 1'b1);
      check("prog_val", timer_set_val, dl[w]);
      check("prog_gid", grant_id, w);
      check("prog_busy", busy, 1'b1);
      check("prog_ready", req_ready, '0);
      if (prog_stale) timer_is_high = 1'b1;
      @(negedge clk);                       // now in WAIT
      timer_is_high = 1'b0;
      check("wait_set_timer", set_timer, 1'b0);
      check("wait_done", done, '0);
      check("wait_val_hold", timer_set_val, dl[w]);
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         check("wait_busy", busy, 1'b1);
         check("wait_done_lat", done, '0);
      end
      timer_is_high = 1'b1;
      @(negedge clk);                       // expiry sampled: DONE
      timer_is_high = 1'b0;
      check("done_pulse", done, exp_oh);
      check("done_busy", busy, 1'b1);
      check("done_ready", req_ready, '0);
      @(negedge clk);                       // back in IDLE
   endtask

   initial begin : stimulus
      int w;
      int exp_order [5] = '{0, 1, 2, 3, 0};

      rst           = 1'b1;
      req_valid     = '1;
      req_delay     = '0;
      timer_is_high = 1'b1;
`ifdef TIMER_SCHED_CANCEL_EN
      req_cancel    = '0;
`endif
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", req_ready, '0);
      check("rst_done", done, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_gid", grant_id, 0);
      check("rst_set_timer", set_timer, 1'b0);
      check("rst_val", timer_set_val, 0);
      @(negedge clk);
      rst           = 1'b0;
      timer_is_high = 1'b0;

      // Contention: every requester asking. Grants must rotate 0,1,2,3,0.
      for (int i = 0; i < 5; i++) begin
         do_grant('1, i % 3, 1'b0, 1'b0, 1'b0, 32'h0, w);
         check("rr_order", w, exp_order[i]);
      end

      // Single request with a delay of 10.
      do_grant(4'b0001, 3, 1'b0, 1'b0, 1'b1, 32'd10, w);
      check("single_winner", w, 0);

      // Stale expiry pulses in PROGRAM and in IDLE, plus the edge delay values.
      do_grant(4'b0100, 2, 1'b1, 1'b1, 1'b1, 32'h0000_0000, w);
      do_grant(4'b1000, 0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, w);

      // Randomized requests, timer latencies and stale pulses.
      for (int i = 0; i < 16; i++) begin
         do_grant(N'($urandom_range(1, 15)), $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'b0, 32'h0, w);
      end

      // Reset during WAIT while requester 2 owns the timer.
      req_valid = 4'b0100;
      #1;
      check("rw_ready", req_ready, N'(1) << rr_pick(4'b0100, model_last));
      @(negedge clk);                       // PROGRAM
      @(negedge clk);                       // WAIT
      check("rw_gid", grant_id, 2);
      #2 rst = 1'b1;                        // asserted between edges
      #1;
      check("rw_busy", busy, 1'b0);
      check("rw_gid_rst", grant_id, 0);
      check("rw_set_timer", set_timer, 1'b0);
      check("rw_val", timer_set_val, 0);
      check("rw_done", done, '0);
      check("rw_ready_rst", req_ready, '0);
      timer_is_high = 1'b1;
      req_valid     = 4'b0101;
      @(negedge clk);
      check("rw_no_done", done, '0);
      timer_is_high = 1'b0;
      rst           = 1'b0;
      model_last    = N - 1;
      model_gid     = 0;
      do_grant(4'b0101, 1, 1'b0, 1'b0, 1'b0, 32'h0, w);
      check("rw_first_after", w, 0);

`ifdef TIMER_SCHED_CANCEL_EN
      // Owner cancel in WAIT. A non-owner cancel beforehand has no effect.
      req_valid = 4'b0010;
      #1;
      check("cx_ready", req_ready, N'(1) << rr_pick(4'b0010, model_last));
      model_last = 1;
      model_gid  = 1;
      @(negedge clk);                       // PROGRAM
      @(negedge clk);                       // WAIT
      req_valid  = '0;
      req_cancel = 4'b1000;
      @(negedge clk);
      check("cx_foreign_busy", busy, 1'b1);
      check("cx_foreign_gid", grant_id, 1);
      req_cancel = 4'b0010;
      @(negedge clk);
      req_cancel = '0;
      check("cx_idle", busy, 1'b0);
      check("cx_no_done", done, '0);
      timer_is_high = 1'b1;
      @(negedge clk);
      timer_is_high = 1'b0;
      check("cx_late_expiry", done, '0);
      check("cx_late_busy", busy, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shares one programmable digital countdown timer among `NUM_REQ` requesters. Each requester asks for a delay; the scheduler grants requests round-robin, programs the timer, waits for expiry and returns a one-cycle `done` pulse to the owner. It sits between the core-side agents (pipeline stall logic, vector unit, debug) and the single timer instance, which it drives through its `set_timer`/`timer_set_val`/`timer_is_high` interface.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the grant index.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in NUM_REQ: requester i wants a timed delay.
- `req_delay` in NUM_REQ*32: delay of requester i, in slice [32*i +: 32].
- `req_ready` out NUM_REQ: one-hot, combinational. Request i is accepted in the cycle `req_valid[i] & req_ready[i]`.
- `done` out NUM_REQ: registered, one-hot, one-cycle pulse when the granted delay expires.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out ID_W: index of the current owner. Holds its value while not busy.
- `set_timer` out 1: registered one-cycle pulse that programs the timer.
- `timer_set_val` out 32: value loaded into the timer. Valid while `set_timer` is high and held afterwards.
- `timer_is_high` in 1: expiry pulse from the timer.

## Operation
- FSM states:
  - IDLE: ready to accept a request.
  - PROGRAM: drives `set_timer`.
  - WAIT: waits for the timer to expire.
  - DONE: drives the `done` pulse.
- IDLE:
  - If any `req_valid` bit is set, the arbiter picks a winner w.
  - `req_ready[w]` is 1. All other `req_ready` bits are 0.
  - At the clock edge: capture `req_delay[w]` into `delay_q`, set `grant_id`<=w, go to PROGRAM.
  - `req_ready` is all-zero in every state except IDLE.
- Arbitration:
  - Round-robin. Search starts at `(last_grant+1) mod NUM_REQ`.
  - `last_grant` resets to NUM_REQ-1, so requester 0 has priority after reset.
  - `last_grant` updates only on acceptance.
- PROGRAM: `set_timer`=1 and `timer_set_val`=`delay_q` for exactly one cycle, then go to WAIT. `timer_is_high` is ignored in this cycle, so a stale expiry from a previous programming is discarded.
- WAIT: the first cycle with `timer_is_high`=1 moves the FSM to DONE. Before that, it stays in WAIT indefinitely.
- DONE: `done[grant_id]`=1 for one cycle, then go to IDLE.
- `timer_is_high` is ignored in IDLE and DONE. The free-running timer may keep firing without effect.
- Delay value 0 is legal and is passed to the timer unchanged. There is no arithmetic on the delay: it is 32 bits in and 32 bits out.
- A requester holding `req_valid` high during its own grant sees no second acceptance until the FSM returns to IDLE.

## Timing
- Reset values:
  - state=IDLE
  - `req_ready`=0 (while `rst` is high)
  - `done`=0
  - `busy`=0
  - `grant_id`=0
  - `set_timer`=0
  - `timer_set_val`=0
  - `delay_q`=0
  - `last_grant`=NUM_REQ-1
- Reset mid-operation: all outputs return to their reset values immediately. No `done` pulse is issued for the aborted grant.
- Accept at edge T: `set_timer` is high during cycle T+1. WAIT begins at T+2.
- `timer_is_high` sampled high at edge E while in WAIT: `done` is high during cycle E+1. The FSM is in IDLE at E+2 and can accept again in that cycle.
- Minimum spacing between accepts is 4 cycles plus the timer latency.
- Simultaneous requests: exactly one is accepted per IDLE cycle. The others see `req_ready`=0 and keep waiting.

## Configuration
- `TIMER_SCHED_CANCEL_EN` defined:
  - Adds input `req_cancel` [NUM_REQ].
  - If `req_cancel[grant_id]`=1 in PROGRAM or WAIT, the FSM goes directly to IDLE at the next edge.
  - No `done` pulse is issued. The next owner reprograms the timer before any expiry is used.
  - Cancel bits for non-owners are ignored, as are cancel bits in IDLE and DONE.
- `TIMER_SCHED_CANCEL_EN` undefined: there is no `req_cancel` port, and a grant always ends with `done`.

## Test plan
- Reset, then a single request: `req_valid`=4'b0001, delay=10. Expect `set_timer` for one cycle with `timer_set_val`=10, then `done`=4'b0001 one cycle after the modelled timer's `timer_is_high`, then `busy`=0.
- Contention: `req_valid`=4'b1111 held high after reset. Expect grant order 0,1,2,3,0 and exactly one `done` pulse per grant, one-hot, matching `grant_id`.
- Stale expiry: `timer_is_high` forced to 1 during the PROGRAM cycle and during IDLE. Expect no state change and no `done`. A later pulse in WAIT produces `done`.
- Edge values: delay=0 and delay=32'hFFFF_FFFF. Expect `timer_set_val` to carry each value unchanged, and `done` to follow `timer_is_high` by one cycle.
- Reset during WAIT, with requester 2 granted: assert `rst` asynchronously between edges. Expect all outputs to reset immediately and no `done[2]`. After release, a pending request from requester 0 is granted first.
- With `TIMER_SCHED_CANCEL_EN`: requester 1 in WAIT, `req_cancel`=4'b0010. Expect IDLE at the next edge with no `done`. A cancel from requester 3 during requester 1's grant has no effect.
